// File: rtl/das_sum_sequencer.sv
// das_sum_sequencer: walks the delay table per (channel, sample), fetches delayed samples and writes per-sample channel sums
module das_sum_sequencer #(
    parameter int NUM_CH     = 8,
    parameter int NUM_SAMP   = 768,
    parameter int DATA_W     = 32,
    parameter int SUM_W      = 40,
    parameter int ADDR_W     = 13,
    parameter int SUM_ADDR_W = 10,
    parameter int PROC_DEPTH = 6144
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     dly_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  dly_rd_en,
    output logic [ADDR_W-1:0]     dly_rd_addr,
    input  logic [ADDR_W-1:0]     dly_rd_data,
    output logic                  proc_rd_en,
    output logic [ADDR_W-1:0]     proc_rd_addr,
    input  logic [DATA_W-1:0]     proc_rd_data,
    output logic                  sum_wr_en,
    output logic [SUM_ADDR_W-1:0] sum_wr_addr,
    output logic [SUM_W-1:0]      sum_wr_data
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW = NUM_SAMP > 1 ? $clog2(NUM_SAMP) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_n;
    logic [CW-1:0] c, c_n, s1_c, s2_c;
    logic [TW-1:0] t, t_n, s1_t, s2_t;
    logic [ADDR_W-1:0] base;
    logic s1_v, s2_v, s2_zero, last_c, last, proc_ok;
    logic [SUM_W-1:0] acc, acc_n, term;

    assign last_c  = c == CW'(NUM_CH - 1);
    assign last    = last_c && t == TW'(NUM_SAMP - 1);
    assign c_n     = last_c ? '0 : c + 1'b1;
    assign t_n     = last_c ? t + 1'b1 : t;
    assign proc_ok = s1_v && ({1'b0, dly_rd_data} < (ADDR_W + 1)'(PROC_DEPTH));
    assign proc_rd_en   = proc_ok;
    assign proc_rd_addr = proc_ok ? dly_rd_data : '0;
    assign term  = s2_zero ? '0 : {{(SUM_W - DATA_W){proc_rd_data[DATA_W-1]}}, proc_rd_data};
    assign acc_n = s2_c == '0 ? term : acc + term;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state: run until the last issue, then drain the two pipeline stages
    always_comb begin
        state_n = state == IDLE  ? (start ? RUN : IDLE) :
                  state == RUN   ? (last ? DRAIN : RUN) :
                  state == DRAIN ? (s1_v || s2_v ? DRAIN : DONE) : IDLE;
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        busy      = state == RUN || state == DRAIN;
        done      = state == DONE;
        dly_rd_en = state == RUN;
    end

    // issue counters and delay-table address, one issue per RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            c           <= '0;
            t           <= '0;
            base        <= '0;
            dly_rd_addr <= '0;
        end else if (state == IDLE && start) begin
            c           <= '0;
            t           <= '0;
            base        <= dly_base;
            dly_rd_addr <= dly_base;
        end else if (state == RUN) begin
            c           <= c_n;
            t           <= t_n;
            dly_rd_addr <= last ? '0 : base + ADDR_W'(c_n) * ADDR_W'(NUM_SAMP) + ADDR_W'(t_n);
        end
    end

    // pipeline tags follow each issue through the two RAM latencies
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_c    <= '0;
            s1_t    <= '0;
            s2_v    <= 1'b0;
            s2_c    <= '0;
            s2_t    <= '0;
            s2_zero <= 1'b0;
        end else begin
            s1_v    <= dly_rd_en;
            s1_c    <= c;
            s1_t    <= t;
            s2_v    <= s1_v;
            s2_c    <= s1_c;
            s2_t    <= s1_t;
            s2_zero <= !proc_ok;
        end
    end

    // sticky out-of-range flag, cleared when a frame is accepted
    always_ff @(posedge clk) begin
        if (reset)                     err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if (s1_v && !proc_ok)     err <= 1'b1;
    end

    // accumulate channel terms and emit the sum on the last channel
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            sum_wr_en   <= 1'b0;
            sum_wr_addr <= '0;
            sum_wr_data <= '0;
        end else begin
            sum_wr_en <= s2_v && s2_c == CW'(NUM_CH - 1);
            if (s2_v) acc <= acc_n;
            if (s2_v && s2_c == CW'(NUM_CH - 1)) begin
                sum_wr_addr <= SUM_ADDR_W'(s2_t);
                sum_wr_data <= acc_n;
            end
        end
    end
endmodule

// File: tb/tb_das_sum_sequencer.sv
// tb_das_sum_sequencer: directed frames with RAM models and hand-computed sums/timing
module tb_das_sum_sequencer;
    localparam int N = 6144;
    logic clk = 0, reset = 1, start = 0;
    logic [12:0] dly_base = 0;
    logic busy, done, err, dly_rd_en, proc_rd_en, sum_wr_en;
    logic [12:0] dly_rd_addr, proc_rd_addr;
    logic [12:0] dly_rd_data = 0;
    logic [31:0] proc_rd_data = 0;
    logic [9:0] sum_wr_addr;
    logic [39:0] sum_wr_data;
    logic [12:0] dly_mem [8192];
    logic [31:0] proc_mem [8192];
    logic [39:0] sum_mem [768];
    int n_tests = 0, n_fail = 0, bad, act;
    int cyc = 0, f_en = 0, w_first = 0, w_last = 0, d_cyc = 0, gap = 0, idx = 0, addr_err = 0, busy_cnt = 0, nwr = 0;
    logic en_prev = 0;
    logic [12:0] first_addr = 0, mon_base = 0, exp_a;

    always #5 clk = ~clk;

    das_sum_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .dly_base(dly_base),
        .busy(busy), .done(done), .err(err),
        .dly_rd_en(dly_rd_en), .dly_rd_addr(dly_rd_addr), .dly_rd_data(dly_rd_data),
        .proc_rd_en(proc_rd_en), .proc_rd_addr(proc_rd_addr), .proc_rd_data(proc_rd_data),
        .sum_wr_en(sum_wr_en), .sum_wr_addr(sum_wr_addr), .sum_wr_data(sum_wr_data)
    );

    always @(posedge clk) begin
        if (dly_rd_en) dly_rd_data <= dly_mem[dly_rd_addr];
        if (proc_rd_en) proc_rd_data <= proc_mem[proc_rd_addr];
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dly_rd_en && !en_prev) begin
            gap = cyc - d_cyc;
            f_en = cyc;
            idx = 0;
            addr_err = 0;
            busy_cnt = 0;
            nwr = 0;
            first_addr = dly_rd_addr;
        end
        if (dly_rd_en) begin
            exp_a = 13'((int'(mon_base) + (idx % 8) * 768 + idx / 8) % 8192);
            if (dly_rd_addr != exp_a) addr_err = addr_err + 1;
            idx = idx + 1;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        if (sum_wr_en) begin
            if (nwr == 0) w_first = cyc;
            w_last = cyc;
            nwr = nwr + 1;
            sum_mem[sum_wr_addr] = sum_wr_data;
        end
        if (done) d_cyc = cyc;
        en_prev = dly_rd_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 7000) begin
            @(negedge clk); #1;
            k++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_frame(input string tag, input logic [12:0] b);
        @(negedge clk); #1;
        mon_base = b;
        dly_base = b;
        start = 1;
        @(negedge clk); #1;
        start = 0;
        wait_done(tag);
    endtask

    task automatic frame_checks(input string tag);
        check({tag, "_done_lat"}, d_cyc - f_en, N + 3);
        check({tag, "_first_wr"}, w_first - f_en, 10);
        check({tag, "_last_wr"}, w_last - f_en, N + 2);
        check({tag, "_busy_cycles"}, busy_cnt, N + 3);
        check({tag, "_writes"}, nwr, 768);
        check({tag, "_addr_seq"}, addr_err, 0);
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) begin
            dly_mem[k] = 13'(k);
            proc_mem[k] = k;
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_enables", {dly_rd_en, proc_rd_en, sum_wr_en}, 0);
        check("rst_addrs", {dly_rd_addr, proc_rd_addr, sum_wr_addr}, 0);
        check("rst_data", sum_wr_data, 0);
        reset = 0;

        run_frame("ident", 0);
        frame_checks("ident");
        check("ident_err", err, 0);
        check("ident_sum0", sum_mem[0], 21504);
        check("ident_sum767", sum_mem[767], 27640);
        bad = 0;
        for (int t = 0; t < 768; t++) if (sum_mem[t] != 40'(21504 + 8 * t)) bad++;
        check("ident_all_sums", bad, 0);

        for (int k = 0; k < 6144; k++) dly_mem[k] = 13'd100;
        proc_mem[100] = 32'hFFFF_FFFF;
        run_frame("sext", 0);
        check("sext_sum0", sum_mem[0], 40'hFF_FFFF_FFF8);
        bad = 0;
        for (int t = 0; t < 768; t++) if (sum_mem[t] != 40'hFF_FFFF_FFF8) bad++;
        check("sext_all_sums", bad, 0);
        check("sext_err", err, 0);

        for (int k = 0; k < 8192; k++) begin
            dly_mem[k] = 13'(k);
            proc_mem[k] = 1;
        end
        dly_mem[3 * 768 + 5] = 13'd6144;
        run_frame("oor", 0);
        check("oor_sum5", sum_mem[5], 7);
        bad = 0;
        for (int t = 0; t < 768; t++) if (t != 5 && sum_mem[t] != 40'd8) bad++;
        check("oor_other_sums", bad, 0);
        check("oor_err", err, 1);

        dly_mem[3 * 768 + 5] = 13'(3 * 768 + 5);
        @(negedge clk); #1;
        mon_base = 0;
        dly_base = 0;
        start = 1;
        @(negedge clk); #1;
        wait_done("b2b_a");
        check("b2b_a_done_lat", d_cyc - f_en, N + 3);
        check("b2b_a_busy_cycles", busy_cnt, N + 3);
        check("b2b_a_writes", nwr, 768);
        check("b2b_a_err_cleared", err, 0);
        @(negedge clk); #1;
        wait_done("b2b_b");
        start = 0;
        check("b2b_gap", gap, 2);
        frame_checks("b2b_b");
        bad = 0;
        for (int t = 0; t < 768; t++) if (sum_mem[t] != 40'd8) bad++;
        check("b2b_b_sums", bad, 0);
        act = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (busy || dly_rd_en) act++;
        end
        check("b2b_no_restart", act, 0);

        for (int k = 0; k < 8192; k++) dly_mem[k] = 13'd7;
        run_frame("wrap", 13'd8000);
        check("wrap_first_addr", first_addr, 8000);
        frame_checks("wrap");
        check("wrap_sum0", sum_mem[0], 8);
        check("wrap_err", err, 0);

        for (int k = 0; k < 8192; k++) begin
            dly_mem[k] = 13'(k);
            proc_mem[k] = k;
        end
        @(negedge clk); #1;
        mon_base = 0;
        dly_base = 0;
        start = 1;
        @(negedge clk); #1;
        start = 0;
        repeat (2999) begin
            @(negedge clk); #1;
        end
        check("mrst_busy_before", busy, 1);
        reset = 1;
        @(negedge clk); #1;
        reset = 0;
        check("mrst_busy", busy, 0);
        check("mrst_enables", {dly_rd_en, proc_rd_en, sum_wr_en}, 0);
        act = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (busy || dly_rd_en || proc_rd_en || sum_wr_en) act++;
        end
        check("mrst_quiet", act, 0);
        run_frame("mrst_next", 0);
        frame_checks("mrst_next");
        bad = 0;
        for (int t = 0; t < 768; t++) if (sum_mem[t] != 40'(21504 + 8 * t)) bad++;
        check("mrst_next_sums", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
